// File: rtl/max_unpool_3d_stream.sv
// rtl/max_unpool_3d_stream.sv - streaming 2x2x2 stride-2 MaxUnpool3d, raster-order output
// Optional double-buffered plane storage when MAX_UNPOOL_PINGPONG_EN is defined.
module max_unpool_3d_stream #(
  parameter int DATA_W = 32,
  parameter int WP     = 4,
  parameter int HP     = 4,
  parameter int DP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int DEPTH = WP * HP;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(2 * WP);
  localparam int RW    = $clog2(2 * HP);
  localparam int PLW   = (DP > 1) ? $clog2(DP) : 1;
`ifdef MAX_UNPOOL_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic [PW-1:0]  PTR_MAX   = PW'(DEPTH - 1);
  localparam logic [CW-1:0]  COL_MAX   = CW'(2 * WP - 1);
  localparam logic [RW-1:0]  ROW_MAX   = RW'(2 * HP - 1);
  localparam logic [PLW-1:0] PLANE_MAX = PLW'(DP - 1);

  // Each entry stores {idx, data}.
  logic [DATA_W+2:0] mem [NB][DEPTH];
  logic [DATA_W+2:0] rd_word;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              dz;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [PLW-1:0]    plane;
  logic              load_en;
  logic              emit_en;
  logic              lbank;
  logic              ebank;
  logic              in_fire;
  logic              out_fire;
  logic              wr_last;
  logic              emit_last;

  assign in_ready  = !rst && load_en;
  assign out_valid = !rst && emit_en;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_last   = (wr_ptr == PTR_MAX);
  assign emit_last = dz && (r == ROW_MAX) && (c == COL_MAX);

`ifdef MAX_UNPOOL_PINGPONG_EN
  // Banks fill and drain in the same order, so ebank always names the oldest full bank.
  logic [1:0] full;

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 2'b00;
      lbank <= 1'b0;
      ebank <= 1'b0;
    end else begin
      if (in_fire && wr_last) begin
        full[lbank] <= 1'b1;
        lbank       <= !lbank;
      end
      if (out_fire && emit_last) begin
        full[ebank] <= 1'b0;
        ebank       <= !ebank;
      end
    end
  end

  assign load_en = !full[lbank];
  assign emit_en = full[ebank];
`else
  typedef enum logic {LOAD, EMIT} state_t;
  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_fire && wr_last) state_next = EMIT;
      EMIT:    if (out_fire && emit_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  assign lbank   = 1'b0;
  assign ebank   = 1'b0;
  assign load_en = (state == LOAD);
  assign emit_en = (state == EMIT);
`endif

  always_ff @(posedge clk) begin
    if (in_fire) mem[lbank][wr_ptr] <= {in_idx, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      dz     <= 1'b0;
      r      <= '0;
      c      <= '0;
      plane  <= '0;
    end else begin
      if (in_fire) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
      // Column fastest, then row, then sub-plane; plane advances at the end of the second sub-plane.
      if (out_fire) begin
        if (c != COL_MAX) begin
          c <= c + 1'b1;
        end else begin
          c <= '0;
          if (r != ROW_MAX) begin
            r <= r + 1'b1;
          end else begin
            r  <= '0;
            dz <= !dz;
            if (dz) plane <= (plane == PLANE_MAX) ? '0 : plane + 1'b1;
          end
        end
      end
    end
  end

  assign rd_ptr  = PW'(32'(r >> 1) * WP + 32'(c >> 1));
  assign rd_word = mem[ebank][rd_ptr];

  assign out_data = (out_valid && (rd_word[DATA_W +: 3] == {dz, r[0], c[0]}))
                    ? rd_word[DATA_W-1:0] : '0;
  assign out_last = out_valid && emit_last && (plane == PLANE_MAX);

endmodule
